// File: rtl/spike_record_tx.sv
// spike_record_tx
// Captures per-unit detector results, queues spike-flagged results as
// timestamped records and streams each record to the host as two bytes:
// a header {4'hA, unit, event} followed by the 8-bit row timestamp.

module spike_record_tx #(
    parameter int NUM_UNITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_res_valid,
    input  logic [1:0] i_res_unit,
    input  logic       i_res_spike,
    input  logic [1:0] i_res_event,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_overflow,
    input  logic       i_ovf_clear,
    output logic [4:0] o_fifo_level
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);
    localparam logic [2:0] NUM_L   = 3'(NUM_UNITS);
    localparam logic [2:0] LAST_L  = 3'(NUM_UNITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_TS
    } state_t;

    typedef struct packed {
        logic [1:0] unit;
        logic [1:0] evt;
        logic [7:0] ts;
    } record_t;

    // Registers
    state_t          r_state;
    record_t         r_hold;
    logic [7:0]      r_tx_byte;
    logic            r_tx_valid;
    logic            r_overflow;
    logic [4:0]      r_level;
    logic [7:0]      r_ts;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    record_t         r_mem [FIFO_DEPTH];

    // Combinational helpers
    logic            w_unit_ok;
    logic            w_accept;
    logic            w_row_end;
    logic            w_push_req;
    logic            w_empty;
    logic            w_full;
    logic            w_xfer;
    logic            w_pop;
    logic            w_do_push;
    logic            w_drop;
    state_t          w_next_state;
    record_t         w_head;
    record_t         w_next_hold;
    record_t         w_new_rec;

    // Result qualification: out-of-range unit ids are ignored entirely, and
    // the last unit of a row closes the row and advances the timestamp.
    assign w_unit_ok  = ({1'b0, i_res_unit} < NUM_L);
    assign w_accept   = i_ena & i_res_valid & w_unit_ok;
    assign w_row_end  = w_accept & ({1'b0, i_res_unit} == LAST_L);
    assign w_push_req = w_accept & i_res_spike;

    assign w_empty    = (r_level == 5'd0);
    assign w_full     = (r_level == DEPTH_L);
    assign w_xfer     = i_ena & r_tx_valid & i_tx_ready;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_new_rec  = '{unit: i_res_unit, evt: i_res_event, ts: r_ts};

    // A push into a full FIFO is still accepted when a pop frees the head
    // slot at the same edge; otherwise the record is dropped.
    assign w_do_push  = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign w_next_hold = w_pop ? w_head : r_hold;

    // Next-state and pop decision; with ena low nothing moves.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        if (i_ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        w_next_state = ST_TS;
                    end
                end
                ST_TS: begin
                    if (w_xfer) begin
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_next_state = ST_HDR;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, holding record and registered byte outputs; the byte is
    // precomputed from the next state so outputs never depend on inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_tx_byte  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= i_ena && (w_next_state != ST_IDLE);
            if (i_ena) begin
                r_state <= w_next_state;
                r_hold  <= w_next_hold;
                case (w_next_state)
                    ST_HDR:  r_tx_byte <= {4'hA, w_next_hold.unit, w_next_hold.evt};
                    ST_TS:   r_tx_byte <= w_next_hold.ts;
                    default: r_tx_byte <= r_tx_byte;
                endcase
            end
        end
    end

    // Record storage; the head is read before a same-edge write lands.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_new_rec;
        end
    end

    // FIFO pointers and occupancy; the record in the holding register is
    // no longer counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Row timestamp, advanced once per completed sample row, wraps at 255.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ts <= 8'h00;
        end else if (w_row_end) begin
            r_ts <= r_ts + 8'd1;
        end
    end

    // Sticky overflow flag; a drop at the same edge as a clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ena && i_ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_tx_byte    = r_tx_byte;
    assign o_tx_valid   = r_tx_valid;
    assign o_overflow   = r_overflow;
    assign o_fifo_level = r_level;

endmodule

// File: tb/tb_spike_record_tx.sv
// tb_spike_record_tx
// Directed scenarios plus a randomized phase, all checked against a
// queue-based reference model of the record stream.

module tb_spike_record_tx;

    localparam int NU    = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstN;
    logic       ena;
    logic       resValid;
    logic [1:0] resUnit;
    logic       resSpike;
    logic [1:0] resEvent;
    logic       txReady;
    logic       ovfClear;
    logic [7:0] txByte;
    logic       txValid;
    logic       overflow;
    logic [4:0] fifoLevel;

    spike_record_tx #(
        .NUM_UNITS (NU),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_ena       (ena),
        .i_res_valid (resValid),
        .i_res_unit  (resUnit),
        .i_res_spike (resSpike),
        .i_res_event (resEvent),
        .o_tx_byte   (txByte),
        .o_tx_valid  (txValid),
        .i_tx_ready  (txReady),
        .o_overflow  (overflow),
        .i_ovf_clear (ovfClear),
        .o_fifo_level(fifoLevel)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued records, record being sent, bytes left of it
    logic [11:0] mQ[$];
    logic [11:0] mCur;
    int          mLeft;
    logic [7:0]  mTs;
    logic        mOvf;
    logic        mValid;

    logic [7:0]  gotBytes[$];
    int          validCycles;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hdrOf(input logic [11:0] r);
        return {4'hA, r[11:8]};
    endfunction

    function automatic logic [7:0] tsOf(input logic [11:0] r);
        return r[7:0];
    endfunction

    task automatic modelReset();
        mQ.delete();
        mCur   = '0;
        mLeft  = 0;
        mTs    = 8'h00;
        mOvf   = 1'b0;
        mValid = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model over the edge, compare.
    task automatic applyStimulus(input logic v, input logic [1:0] u, input logic s,
                                 input logic [1:0] e, input logic rdy, input logic en,
                                 input logic clr);
        logic        xfer;
        logic        pop;
        logic        full;
        logic        accept;
        logic        setOvf;
        logic        holdChk;
        logic [7:0]  holdByte;
        logic [11:0] rec;
        resValid = v;
        resUnit  = u;
        resSpike = s;
        resEvent = e;
        txReady  = rdy;
        ena      = en;
        ovfClear = clr;
        if (txValid && rdy && en) gotBytes.push_back(txByte);
        if (txValid) validCycles++;
        holdChk  = txValid && !rdy;
        holdByte = txByte;
        if (en) begin
            xfer = mValid && rdy;
            full = (mQ.size() == DEPTH);
            if (xfer) mLeft--;
            pop = 1'b0;
            if (mLeft == 0 && mQ.size() > 0) begin
                mCur  = mQ.pop_front();
                mLeft = 2;
                pop   = 1'b1;
            end
            accept = v && (int'(u) < NU);
            rec    = {u, e, mTs};
            setOvf = accept && s && full && !pop;
            if (accept && s && !setOvf) mQ.push_back(rec);
            if (setOvf) mOvf = 1'b1;
            else if (clr) mOvf = 1'b0;
            if (accept && int'(u) == NU - 1) mTs = mTs + 8'd1;
            mValid = (mLeft > 0);
        end else begin
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("tx_valid", txValid, mValid);
        if (mValid) checkOutput("tx_byte", txByte, (mLeft == 2) ? hdrOf(mCur) : tsOf(mCur));
        checkOutput("fifo_level", fifoLevel, mQ.size());
        checkOutput("overflow", overflow, mOvf);
        if (holdChk && txValid) checkOutput("byte_stable", txByte, holdByte);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, rdy, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        resValid = 1'b0;
        resSpike = 1'b0;
        ovfClear = 1'b0;
        rstN     = 1'b0;
        #1;
        checkOutput("rst_tx_valid", txValid, 0);
        checkOutput("rst_tx_byte", txByte, 0);
        checkOutput("rst_fifo_level", fifoLevel, 0);
        checkOutput("rst_overflow", overflow, 0);
        modelReset();
        gotBytes.delete();
        validCycles = 0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic checkBytes(input string tag, input logic [7:0] exp[$]);
        checkOutput({tag, "_count"}, gotBytes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < gotBytes.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), gotBytes[i], exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp[$];
        rstN     = 1'b1;
        ena      = 1'b1;
        resValid = 1'b0;
        resUnit  = 2'd0;
        resSpike = 1'b0;
        resEvent = 2'd0;
        txReady  = 1'b0;
        ovfClear = 1'b0;
        modelReset();
        #2;

        // Single spike, then a second one proving ts advanced to 1
        $display("[TB] single spike");
        doReset();
        applyStimulus(1'b1, 2'd1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        checkOutput("single_valid_cycles", validCycles, 2);
        applyStimulus(1'b1, 2'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        exp = '{8'hA6, 8'h00, 8'hA0, 8'h01};
        checkBytes("single", exp);

        // Non-spike rows only advance the timestamp
        $display("[TB] non-spike filter");
        doReset();
        for (int r = 0; r < 10; r++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
            applyStimulus(1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("filter_valid_cycles", validCycles, 0);
        checkOutput("filter_level", fifoLevel, 0);
        applyStimulus(1'b1, 2'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        exp = '{8'hA3, 8'h0A};
        checkBytes("filter", exp);

        // Back-pressure with ready toggling every cycle
        $display("[TB] back-pressure");
        doReset();
        applyStimulus(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, (i % 2) == 0, 1'b1, 1'b0);
        end
        exp = '{8'hA1, 8'h00, 8'hA6, 8'h00, 8'hA3, 8'h01};
        checkBytes("backpressure", exp);

        // Overflow with the host stalled
        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'd1, 1'b1, 2'(i), 1'b0, 1'b1, 1'b0);
            if (i == 3) begin
                checkOutput("ovf_peak_level", fifoLevel, 3);
                checkOutput("ovf_peak_flag", overflow, 0);
            end
            if (i == 4) begin
                checkOutput("ovf_full_level", fifoLevel, 4);
                checkOutput("ovf_full_flag", overflow, 0);
            end
            if (i == 5) begin
                checkOutput("ovf_drop_level", fifoLevel, 4);
                checkOutput("ovf_drop_flag", overflow, 1);
            end
        end
        idle(15, 1'b1);
        exp = '{8'hA4, 8'h00, 8'hA5, 8'h01, 8'hA6, 8'h02, 8'hA7, 8'h03, 8'hA4, 8'h04};
        checkBytes("overflow", exp);
        checkOutput("ovf_sticky", overflow, 1);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        checkOutput("ovf_cleared", overflow, 0);

        // Timestamp wraps after 256 rows
        $display("[TB] timestamp wrap");
        doReset();
        for (int r = 0; r < 256; r++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
            applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 2'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        exp = '{8'hA1, 8'h00};
        checkBytes("wrap", exp);

        // Reset while sending the timestamp with two records queued
        $display("[TB] reset mid-record");
        doReset();
        applyStimulus(1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        checkOutput("midrst_level", fifoLevel, 2);
        checkOutput("midrst_ts_byte", txByte, 8'h00);
        idle(1, 1'b0);
        doReset();
        idle(10, 1'b1);
        checkOutput("midrst_bytes_after", gotBytes.size(), 0);
        checkOutput("midrst_valid_after", validCycles, 0);

        // Enable dropped while presenting a header
        $display("[TB] enable freeze");
        doReset();
        applyStimulus(1'b1, 2'd1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        checkOutput("ena_hdr_valid", txValid, 1);
        checkOutput("ena_hdr_byte", txByte, 8'hA6);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
            checkOutput("ena_low_valid", txValid, 0);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("ena_resume_valid", txValid, 1);
        checkOutput("ena_resume_byte", txByte, 8'hA6);
        gotBytes.delete();
        idle(4, 1'b1);
        exp = '{8'hA6, 8'h00};
        checkBytes("ena", exp);

        // Randomized traffic against the model
        $display("[TB] random phase");
        doReset();
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 9),
                          ($urandom_range(0, 19) == 0));
        end
        idle(30, 1'b1);
        checkOutput("random_drained", fifoLevel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
